alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   ID/EX issue stage directly upstream of the MIPS ALU. Accepts decoded instruction fields and
//   register-file operands, produces ALUCtl (4-bit) plus operands A/B. Registered valid/ready
//   pipeline with 2-entry skid buffer, so full throughput holds under back-pressure. Also flushes
//   on branch redirect and counts illegal funct codes.
// PARAMETERS
//   DW       32   operand width (A, B, rs_val, rt_val)
//   CNT_W    16   width of saturating illegal-op counter
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   in_valid     in   1      upstream has an instruction
//   in_ready     out  1      stage can accept (registered: = skid entry empty)
//   alu_op       in   2      00 ADD (lw/sw), 01 SUB (beq), 10 R-type per funct, 11 reserved
//   funct        in   6      R-type function code
//   alu_src      in   1      1: B = sign-extended imm16; 0: B = rt_val
//   rs_val       in   DW     register operand A
//   rt_val       in   DW     register operand B
//   imm16        in   16     immediate
//   flush        in   1      discard all held and incoming entries this cycle
//   out_valid    out  1      ALU inputs valid
//   out_ready    in   1      downstream (ALU/EX latch) accepts
//   alu_ctl      out  4      to ALU ALUCtl
//   alu_a        out  DW     to ALU A
//   alu_b        out  DW     to ALU B
//   illegal      out  1      entry at output had unsupported op (alu_ctl = 15)
//   illegal_cnt  out  CNT_W  saturating count of illegal entries accepted
// BEHAVIOUR
//   Reset (async, rst_n=0): out_valid=0, in_ready=1, alu_ctl=0, alu_a=0, alu_b=0, illegal=0,
//     illegal_cnt=0, skid empty. Outputs return to these values immediately, even mid-transfer.
//   Decode (comb, on input side): alu_op 00->2; 01->6; 10: funct 32->2, 34->6, 36->0, 37->1,
//     39->12, 42->7, other->15 + illegal; 11->15 + illegal.
//   B select: alu_src ? {{DW-16{imm16[15]}},imm16} : rt_val. A = rs_val.
//   Accept = in_valid & in_ready; Emit = out_valid & out_ready. Latency 1 cycle, accept -> out_valid.
//   Main reg holds output entry; skid reg holds 1 overflow entry. States by occupancy:
//     EMPTY (0) -- accept -> ONE.
//     ONE (1)   -- accept&~emit -> TWO (entry to skid); emit&~accept -> EMPTY;
//                  accept&emit -> ONE with new entry.
//     TWO (2)   -- in_ready=0; emit -> ONE, skid moves to main.
//   in_ready = ~skid_full (from flop, never from out_ready combinationally).
//   Outputs stable while out_valid & ~out_ready (no change of alu_ctl/a/b/illegal).
//   flush: next cycle state EMPTY, out_valid=0, in_ready=1. Accept in flush cycle is dropped.
//     An emit in the flush cycle still completes.
//   illegal_cnt: +1 per accepted illegal entry not dropped by flush. Saturates at 2^CNT_W-1,
//     no wrap. Unaffected by flush otherwise.
//   Data regs not reset-qualified beyond listed outputs; skid data don't-care when empty.
// STRUCTURE
//   alu_pkg: ALUCtl localparams (AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, BAD=15),
//     funct codes (32, 34, 36, 37, 39, 42), ALUOp encodings.
//   Sub-module alu_skid_buf #(W): generic 2-entry valid/ready skid buffer with flush, payload
//     {illegal, alu_ctl, alu_a, alu_b}. Decode, B mux and counter stay in top level.
// TESTING
//   1. Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, in_ready=1, illegal_cnt=0
//      without waiting for a clock edge.
//   2. R-type sweep, out_ready=1: funct 32/34/36/37/39/42, rs=5, rt=3 -> alu_ctl 2/6/0/1/12/7
//      one cycle later, A=5, B=3, one result per cycle.
//   3. alu_src=1, alu_op=00, imm16=16'hFFFC, rs=0x100 -> alu_ctl=2, alu_b=32'hFFFF_FFFC.
//   4. Back-pressure: stream 4 entries, out_ready=0 for 3 cycles -> in_ready falls after
//      2 held, no loss/duplication, order preserved after release.
//   5. flush while TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//      dropped entry never appears.
//   6. Illegal: alu_op=10 funct=0, and alu_op=11 -> alu_ctl=15, illegal=1, cnt +1 each.
//      Force cnt to 16'hFFFF -> stays 16'hFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, funct codes and the ALUOp/funct decoder for the issue stage.
package alu_pkg;

    localparam logic [3:0] CTL_AND = 4'd0;
    localparam logic [3:0] CTL_OR  = 4'd1;
    localparam logic [3:0] CTL_ADD = 4'd2;
    localparam logic [3:0] CTL_SUB = 4'd6;
    localparam logic [3:0] CTL_SLT = 4'd7;
    localparam logic [3:0] CTL_NOR = 4'd12;
    localparam logic [3:0] CTL_BAD = 4'd15;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_NOR = 6'd39;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_RTYPE = 2'b10,
        OP_RSVD  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic       illegal;
        logic [3:0] ctl;
    } decode_t;

    // Unsupported ALUOp/funct combinations map to CTL_BAD and raise illegal.
    function automatic decode_t decode_op(input logic [1:0] op, input logic [5:0] fn);
        decode_t d;
        d.illegal = 1'b0;
        d.ctl     = CTL_BAD;
        case (alu_op_t'(op))
            OP_ADD:   d.ctl = CTL_ADD;
            OP_SUB:   d.ctl = CTL_SUB;
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  d.ctl = CTL_ADD;
                    FN_SUB:  d.ctl = CTL_SUB;
                    FN_AND:  d.ctl = CTL_AND;
                    FN_OR:   d.ctl = CTL_OR;
                    FN_NOR:  d.ctl = CTL_NOR;
                    FN_SLT:  d.ctl = CTL_SLT;
                    default: d.illegal = 1'b1;
                endcase
            end
            default:  d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; in_ready and out_valid come straight from flops.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    logic [W-1:0] skid_data;
    logic         accept_c;
    logic         emit_c;

    assign accept_c = in_valid & in_ready;
    assign emit_c   = out_valid & out_ready;

    // Occupancy FSM; main entry sits in out_data and only moves when emitted or refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SKID_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
        end else if (flush) begin
            state     <= SKID_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept_c) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept_c && !emit_c) begin
                        in_ready <= 1'b0;
                        state    <= SKID_TWO;
                    end else if (emit_c && !accept_c) begin
                        out_valid <= 1'b0;
                        state     <= SKID_EMPTY;
                    end else if (accept_c && emit_c) begin
                        out_data <= in_data;
                    end
                end
                SKID_TWO: begin
                    if (emit_c) begin
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                        state    <= SKID_ONE;
                    end
                end
                default: begin
                    state     <= SKID_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Overflow slot; contents are meaningless unless state is SKID_TWO.
    always_ff @(posedge clk) begin
        if (state == SKID_ONE && accept_c && !emit_c) begin
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALUCtl, selects operand B, buffers through a skid buffer, counts illegal ops.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             alu_src,
    input  logic [DW-1:0]    rs_val,
    input  logic [DW-1:0]    rt_val,
    input  logic [15:0]      imm16,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_ctl,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int unsigned PW = 1 + 4 + 2 * DW;

    decode_t       dec_c;
    logic [DW-1:0] b_c;
    logic [PW-1:0] in_data_c;
    logic [PW-1:0] out_data;

    assign dec_c     = decode_op(alu_op, funct);
    assign b_c       = alu_src ? {{(DW - 16){imm16[15]}}, imm16} : rt_val;
    assign in_data_c = {dec_c.illegal, dec_c.ctl, rs_val, b_c};

    alu_skid_buf #(
        .W(PW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data_c),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    assign {illegal, alu_ctl, alu_a, alu_b} = out_data;

    // Count illegal entries that are really accepted (a flush drops the incoming one).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (in_valid && in_ready && !flush && dec_c.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios plus randomized traffic against a reference model.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm16;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  in_ready_s;
    logic        out_valid, out_valid_s;
    logic [3:0]  alu_ctl,   alu_ctl_s;
    logic [31:0] alu_a,     alu_a_s;
    logic [31:0] alu_b,     alu_b_s;
    logic        illegal,   illegal_s;
    logic [15:0] illegal_cnt;
    logic [1:0]  illegal_cnt_s;

    alu_issue_stage #(.DW(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .rs_val(rs_val),
        .rt_val(rt_val), .imm16(imm16), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    alu_issue_stage #(.DW(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .rs_val(rs_val),
        .rt_val(rt_val), .imm16(imm16), .flush(flush), .out_valid(out_valid_s),
        .out_ready(out_ready), .alu_ctl(alu_ctl_s), .alu_a(alu_a_s), .alu_b(alu_b_s),
        .illegal(illegal_s), .illegal_cnt(illegal_cnt_s)
    );

    typedef struct {
        logic [3:0]  ctl;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt_m = 0;
    int   cnt_s = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: MIPS ALU control table and operand selection from the instruction fields.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn, input logic src,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm);
        exp_t e;
        int   c;
        bit   ill;
        ill = 1'b0;
        if (op == 2'd0)      c = 2;
        else if (op == 2'd1) c = 6;
        else if (op == 2'd3) begin c = 15; ill = 1'b1; end
        else begin
            case (int'(fn))
                32: c = 2;
                34: c = 6;
                36: c = 0;
                37: c = 1;
                39: c = 12;
                42: c = 7;
                default: begin c = 15; ill = 1'b1; end
            endcase
        end
        e.ctl = 4'(c);
        e.ill = ill;
        e.a   = rs;
        e.b   = src ? 32'($signed(imm)) : rt;
        return e;
    endfunction

    // Monitor: inputs and outputs are stable at negedge; decide what the next posedge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
            cnt_s = 0;
        end else begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid_sat", 64'(out_valid_s), 64'(q.size() > 0));
            chk("illegal_cnt", 64'(illegal_cnt), 64'(cnt_m));
            chk("illegal_cnt_sat", 64'(illegal_cnt_s), 64'(cnt_s));
            if (out_valid && q.size() > 0) begin
                chk("alu_ctl", 64'(alu_ctl), 64'(q[0].ctl));
                chk("illegal", 64'(illegal), 64'(q[0].ill));
                chk("alu_a", 64'(alu_a), 64'(q[0].a));
                chk("alu_b", 64'(alu_b), 64'(q[0].b));
                chk("alu_ctl_sat", 64'(alu_ctl_s), 64'(q[0].ctl));
                if (out_ready) void'(q.pop_front());
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                exp_t e;
                e = model(alu_op, funct, alu_src, rs_val, rt_val, imm16);
                q.push_back(e);
                if (e.ill) begin
                    if (cnt_m < 65535) cnt_m++;
                    if (cnt_s < 3) cnt_s++;
                end
            end
        end
    end

    // Present one entry and hold it until the DUT accepts it (bounded).
    task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic src,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
        int   n;
        logic took;
        n = 0;
        took = 1'b0;
        in_valid = 1'b1;
        alu_op = op; funct = fn; alu_src = src; rs_val = rs; rt_val = rt; imm16 = imm;
        while (!took && n < 200) begin
            @(negedge clk);
            took = in_ready && !flush;
            @(posedge clk);
            #2;
            n++;
        end
        if (!took) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int fl[6];
        fl = '{32, 34, 36, 37, 39, 42};
        rst_n = 1'b1; in_valid = 1'b0; alu_op = 2'd0; funct = 6'd0; alu_src = 1'b0;
        rs_val = '0; rt_val = '0; imm16 = '0; flush = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_alu_ctl", 64'(alu_ctl), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_cnt", 64'(illegal_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(1);

        // R-type sweep, back to back
        for (int i = 0; i < 6; i++) send(2'b10, 6'(fl[i]), 1'b0, 32'd5, 32'd3, 16'h0);
        idle(2);

        // Immediate operand with sign extension
        send(2'b00, 6'd0, 1'b1, 32'h100, 32'h1234, 16'hFFFC);
        send(2'b01, 6'd0, 1'b1, 32'h7, 32'h0, 16'h7FFF);
        idle(2);

        // Illegal ops; five of them saturate the narrow counter
        send(2'b10, 6'd0, 1'b0, 32'd1, 32'd2, 16'h0);
        send(2'b11, 6'd32, 1'b0, 32'd3, 32'd4, 16'h0);
        for (int i = 0; i < 3; i++) send(2'b11, 6'(i), 1'b1, 32'(i), 32'd0, 16'h8000);
        idle(2);

        // Back-pressure: four entries while downstream stalls three cycles
        fork
            for (int i = 0; i < 4; i++) send(2'b10, 6'(fl[i]), 1'b0, 32'(100 + i), 32'(200 + i), 16'h0);
            begin
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        idle(3);

        // Flush while full with a new entry offered
        out_ready = 1'b0;
        send(2'b00, 6'd0, 1'b0, 32'hA, 32'hB, 16'h0);
        send(2'b01, 6'd0, 1'b0, 32'hC, 32'hD, 16'h0);
        in_valid = 1'b1; alu_op = 2'b11; rs_val = 32'hDEAD; flush = 1'b1;
        idle(1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(2);

        // Asynchronous reset while an entry is held at the output
        out_ready = 1'b0;
        send(2'b10, 6'd0, 1'b0, 32'h55, 32'h66, 16'h0);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_cnt", 64'(illegal_cnt), 64'd0);
        chk("mid_rst_cnt_sat", 64'(illegal_cnt_s), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1; out_ready = 1'b1;
        idle(1);

        // Randomized traffic with back-pressure and occasional flush
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 32) == 0;
            alu_op    = 2'($urandom);
            funct     = (($urandom % 4) == 0) ? 6'($urandom) : 6'(fl[$urandom % 6]);
            alu_src   = 1'($urandom);
            rs_val    = $urandom;
            rt_val    = $urandom;
            imm16     = 16'($urandom);
            idle(1);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(5);
        chk("drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
